// File: rtl/jtag_host_shifter.sv
// JTAG host shifter: runs TAP-reset, IR/DR-shift and idle-clock commands on a
// divided TCK and captures TDO during the shift phase, LSB first.
module jtag_host_shifter #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [6:0]  cmd_len,
  input  logic [63:0] cmd_data,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        busy,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo
);

  typedef enum logic [2:0] {IDLE, PRE, SHIFT, POST, DONE} state_t;
  typedef enum logic [1:0] {
    CMD_RESET = 2'b00,
    CMD_IR    = 2'b01,
    CMD_DR    = 2'b10,
    CMD_IDLE  = 2'b11
  } cmd_t;

  state_t      state, state_nxt;
  cmd_t        type_q, sel_type;
  logic [6:0]  len_q, len_sat, sel_len, pre_len, cnt, cnt_nxt;
  logic [63:0] data_q;
  logic [7:0]  div_cnt;
  logic        tck_end, step_end, zero_sel, active, tms_nxt, tdi_nxt;

  assign len_sat   = (cmd_len > 7'd64) ? 7'd64 : cmd_len;
  // Drive logic sees the incoming command on the acceptance edge, the latched copy afterwards.
  assign sel_type  = (state == IDLE) ? cmd_t'(cmd_type) : type_q;
  assign sel_len   = (state == IDLE) ? len_sat : len_q;
  assign zero_sel  = (sel_type != CMD_RESET) && (sel_len == '0);
  assign active    = (state == PRE || state == SHIFT || state == POST) && !zero_sel;
  assign tck_end   = (div_cnt == 8'(CLK_DIV - 1));
  assign step_end  = tck && tck_end;
  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (state == DONE);

  always_comb begin
    case (type_q)
      CMD_RESET: pre_len = 7'd6;
      CMD_IR:    pre_len = 7'd4;
      CMD_DR:    pre_len = 7'd3;
      default:   pre_len = len_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (cmd_valid) state_nxt = PRE;
      end
      PRE: begin
        if (zero_sel) begin
          state_nxt = DONE;
        end else if (step_end) begin
          if (cnt == pre_len - 7'd1) begin
            cnt_nxt   = '0;
            state_nxt = (type_q == CMD_RESET || type_q == CMD_IDLE) ? DONE : SHIFT;
          end else begin
            cnt_nxt = cnt + 7'd1;
          end
        end
      end
      SHIFT: begin
        if (step_end) begin
          if (cnt == len_q - 7'd1) begin
            cnt_nxt   = '0;
            state_nxt = POST;
          end else begin
            cnt_nxt = cnt + 7'd1;
          end
        end
      end
      POST: begin
        if (step_end) begin
          if (cnt == 7'd1) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + 7'd1;
          end
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Pin values are a function of the upcoming (state, step); they only change where a step begins.
  always_comb begin
    tms_nxt = tms;
    tdi_nxt = 1'b0;
    case (state_nxt)
      PRE: begin
        if (!zero_sel) begin
          case (sel_type)
            CMD_RESET: tms_nxt = (cnt_nxt < 7'd5);
            CMD_IR:    tms_nxt = (cnt_nxt < 7'd2);
            CMD_DR:    tms_nxt = (cnt_nxt == '0);
            default:   tms_nxt = 1'b0;
          endcase
        end
      end
      SHIFT: begin
        tms_nxt = (cnt_nxt == len_q - 7'd1);
        tdi_nxt = data_q[cnt_nxt[5:0]];
      end
      POST:    tms_nxt = (cnt_nxt == '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      type_q   <= CMD_RESET;
      len_q    <= '0;
      data_q   <= '0;
      div_cnt  <= '0;
      tck      <= 1'b0;
      tms      <= 1'b1;
      tdi      <= 1'b0;
      rsp_data <= '0;
    end else begin
      tms <= tms_nxt;
      tdi <= tdi_nxt;
      if (active) begin
        if (tck_end) begin
          div_cnt <= '0;
          tck     <= ~tck;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end else begin
        div_cnt <= '0;
        tck     <= 1'b0;
      end
      if (state == IDLE && cmd_valid) begin
        type_q   <= cmd_t'(cmd_type);
        len_q    <= len_sat;
        data_q   <= cmd_data;
        rsp_data <= '0;
      end
      if (state == SHIFT && step_end) rsp_data[cnt[5:0]] <= tdo;
    end
  end

endmodule

// File: tb/tb_jtag_host_shifter.sv
// Bench for jtag_host_shifter: directed vector table, hand-written abort and
// busy sequences, and random commands checked against a command-level model.
module tb_jtag_host_shifter;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_type = '0;
  logic [6:0]  cmd_len = '0;
  logic [63:0] cmd_data = '0;
  logic        cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo;
  logic [63:0] rsp_data;

  logic        tdo_lb = 1'b1;
  logic [63:0] tdo_pat = '0;
  logic [31:0] edge_cnt = '0;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [1:0]  t;
    logic [6:0]  len;
    logic [63:0] d;
    logic        lb;
    logic [63:0] p;
    int          ntck;
    logic [63:0] rsp;
  } vec_t;

  vec_t tab[11];

  jtag_host_shifter #(.CLK_DIV(D)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
  );

  always #5 clk = ~clk;

  // Target model: loopback, or a pattern that advances on every TCK edge.
  always @(posedge tck or negedge tck) edge_cnt <= edge_cnt + 32'd1;
  assign tdo = tdo_lb ? tdi : tdo_pat[edge_cnt[5:0]];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic run_cmd(input logic [1:0] t, input logic [6:0] len, input logic [63:0] d,
                         input logic lb, input logic [63:0] p, input int exp_n,
                         input logic [63:0] exp_r);
    int           eff, pre, ntck, lat, n_valid, wave_err, stab_err, hs_err, n_rise;
    logic         exp_tms[$], exp_tdi[$];
    logic [127:0] exp_tms_v, exp_tdi_v, obs_tms_v, obs_tdi_v;
    logic [63:0]  rsp_e;
    logic [31:0]  base;
    logic         prev_tck, prev_tms, prev_tdi, e_tck;

    eff = (len > 7'd64) ? 64 : int'(len);
    pre = 0;
    case (t)
      2'b00: begin
        pre = 6;
        for (int i = 0; i < 6; i++) begin
          exp_tms.push_back((i < 5) ? 1'b1 : 1'b0);
          exp_tdi.push_back(1'b0);
        end
      end
      2'b11: begin
        for (int i = 0; i < eff; i++) begin
          exp_tms.push_back(1'b0);
          exp_tdi.push_back(1'b0);
        end
      end
      default: begin
        if (eff > 0) begin
          pre = (t == 2'b01) ? 4 : 3;
          for (int i = 0; i < pre; i++) begin
            exp_tms.push_back((i == 0 || (t == 2'b01 && i == 1)) ? 1'b1 : 1'b0);
            exp_tdi.push_back(1'b0);
          end
          for (int i = 0; i < eff; i++) begin
            exp_tms.push_back((i == eff - 1) ? 1'b1 : 1'b0);
            exp_tdi.push_back(d[i]);
          end
          exp_tms.push_back(1'b1); exp_tdi.push_back(1'b0);
          exp_tms.push_back(1'b0); exp_tdi.push_back(1'b0);
        end
      end
    endcase
    exp_tms_v = '0;
    exp_tdi_v = '0;
    for (int i = 0; i < exp_tms.size() && i < 128; i++) begin
      exp_tms_v[i] = exp_tms[i];
      exp_tdi_v[i] = exp_tdi[i];
    end

    @(negedge clk);
    tdo_lb   = lb;
    tdo_pat  = p;
    cmd_type = t;
    cmd_len  = len;
    cmd_data = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    base = edge_cnt;
    #1 cmd_valid = 1'b0;

    rsp_e = '0;
    if (t == 2'b01 || t == 2'b10)
      for (int i = 0; i < eff; i++)
        rsp_e[i] = lb ? d[i] : p[(int'(base[5:0]) + 2 * (pre + i) + 1) % 64];
    ntck = exp_tms.size();
    if (exp_n >= 0) begin
      ntck  = exp_n;
      rsp_e = exp_r;
    end
    lat = (ntck == 0) ? 2 : ntck * 2 * D + 1;

    n_valid = 0; wave_err = 0; stab_err = 0; hs_err = 0; n_rise = 0;
    obs_tms_v = '0; obs_tdi_v = '0;
    prev_tck = 1'b0; prev_tms = tms; prev_tdi = tdi;
    for (int n = 1; n <= lat + 20 && n_valid == 0; n++) begin
      @(negedge clk);
      e_tck = (n <= ntck * 2 * D) && (((n - 1) % (2 * D)) >= D);
      if (tck !== e_tck) wave_err++;
      if (tck === 1'b1 && prev_tck === 1'b0) begin
        if (n_rise < 128) begin
          obs_tms_v[n_rise] = tms;
          obs_tdi_v[n_rise] = tdi;
        end
        n_rise++;
      end
      if (n > 1 && (tms !== prev_tms || tdi !== prev_tdi) && !(tck === 1'b0 && prev_tck === 1'b1))
        stab_err++;
      if (n < lat && (cmd_ready !== 1'b0 || busy !== 1'b1)) hs_err++;
      if (n == 1 && rsp_data !== '0) hs_err++;
      if (rsp_valid === 1'b1) n_valid = n;
      prev_tck = tck; prev_tms = tms; prev_tdi = tdi;
    end

    check("latency", n_valid, lat);
    check("tck_wave", wave_err, 0);
    check("tck_count", n_rise, ntck);
    check("tms_seq", obs_tms_v, exp_tms_v);
    check("tdi_seq", obs_tdi_v, exp_tdi_v);
    check("pin_hold", stab_err, 0);
    check("busy_ready", hs_err, 0);
    check("rsp_data", rsp_data, rsp_e);
    @(negedge clk);
    check("after_done", {rsp_valid, cmd_ready, busy, tck, tdi, (rsp_data === rsp_e)}, 6'b010001);
    if (ntck > 0) check("tms_rest", tms, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rises, pulses;
    logic        prev;
    logic [1:0]  t;
    logic [6:0]  len;
    logic [63:0] d, p;
    logic        lb;

    tab[0]  = '{2'b00, 7'h55,  64'hDEAD_BEEF_0123_4567, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 6,  64'h0};
    tab[1]  = '{2'b10, 7'd8,   64'hA5,                  1'b1, 64'h0, 13, 64'hA5};
    tab[2]  = '{2'b01, 7'd10,  64'h3FF,                 1'b0, 64'h0, 16, 64'h0};
    tab[3]  = '{2'b10, 7'd100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0, 69, 64'hFFFF_FFFF_FFFF_FFFF};
    tab[4]  = '{2'b11, 7'd0,   64'h0,                   1'b1, 64'h0, 0,  64'h0};
    tab[5]  = '{2'b11, 7'd5,   64'hFF,                  1'b1, 64'h0, 5,  64'h0};
    tab[6]  = '{2'b10, 7'd0,   64'hFF,                  1'b1, 64'h0, 0,  64'h0};
    tab[7]  = '{2'b01, 7'd1,   64'h1,                   1'b1, 64'h0, 7,  64'h1};
    tab[8]  = '{2'b10, 7'd64,  64'h0123_4567_89AB_CDEF, 1'b1, 64'h0, 69, 64'h0123_4567_89AB_CDEF};
    tab[9]  = '{2'b10, 7'd3,   64'hFF,                  1'b1, 64'h0, 8,  64'h7};
    tab[10] = '{2'b01, 7'd65,  64'h8000_0000_0000_0001, 1'b1, 64'h0, 70, 64'h8000_0000_0000_0001};

    #1 reset_n = 1'b0;
    #2;
    check("reset_pins", {tck, tms, tdi, cmd_ready, busy, rsp_valid}, 6'b010100);
    check("reset_rsp", rsp_data, 64'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run_cmd(tab[i].t, tab[i].len, tab[i].d, tab[i].lb, tab[i].p, tab[i].ntck, tab[i].rsp);

    // cmd_valid held high (with changed fields) while an idle command runs
    @(negedge clk);
    tdo_lb = 1'b1; cmd_type = 2'b11; cmd_len = 7'd3; cmd_data = '0; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_type = 2'b10; cmd_len = 7'd5; cmd_data = 64'hFFFF_FFFF_FFFF_FFFF;
    rises = 0; pulses = 0; prev = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (tck === 1'b1 && prev === 1'b0) rises++;
      prev = tck;
      if (rsp_valid === 1'b1) begin
        pulses++;
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    check("busy_rises", rises, 3);
    check("busy_pulses", pulses, 1);
    check("busy_ready_after", cmd_ready, 1'b1);

    // reset pulse during shift bit 3 of a DR shift
    @(negedge clk);
    tdo_lb = 1'b1; cmd_type = 2'b10; cmd_len = 7'd8; cmd_data = 64'hA5; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    rises = 0; prev = 1'b0;
    for (int n = 0; n < 200 && rises < 7; n++) begin
      @(negedge clk);
      if (tck === 1'b1 && prev === 1'b0) rises++;
      prev = tck;
    end
    check("abort_reached_bit3", rises, 7);
    #1 reset_n = 1'b0;
    #1;
    check("abort_pins", {tck, tms, tdi, cmd_ready, busy, rsp_valid}, 6'b010100);
    check("abort_rsp", rsp_data, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    repeat (80) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) pulses++;
    end
    check("abort_no_rsp", pulses, 0);
    run_cmd(2'b00, 7'd0, 64'h0, 1'b0, 64'h0, 6, 64'h0);

    repeat (25) begin
      t   = 2'($urandom_range(0, 3));
      len = 7'($urandom_range(0, 72));
      d   = {$urandom, $urandom};
      lb  = 1'($urandom_range(0, 1));
      p   = {$urandom, $urandom};
      run_cmd(t, len, d, lb, p, -1, 64'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
